// File: rtl/transform_sequencer.sv
// Sequences an external matrix_transform engine over a short programmable chain of steps per 2-D point.
// Optional macro SEQ_PERF_CNT_EN adds the perf_points / perf_timeouts counters.
module transform_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_STEPS  = 4,
  parameter int TIMEOUT    = 64,
  localparam int AW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1,
  localparam int LW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [1:0]            cfg_type,
  input  logic [DATA_WIDTH-1:0] cfg_p1,
  input  logic [DATA_WIDTH-1:0] cfg_p2,
  input  logic [LW-1:0]         cfg_len,
  input  logic                  pt_valid,
  output logic                  pt_ready,
  input  logic [DATA_WIDTH-1:0] pt_x,
  input  logic [DATA_WIDTH-1:0] pt_y,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_x,
  output logic [DATA_WIDTH-1:0] res_y,
  output logic                  eng_start,
  output logic [DATA_WIDTH-1:0] eng_x,
  output logic [DATA_WIDTH-1:0] eng_y,
  output logic [1:0]            eng_type,
  output logic [DATA_WIDTH-1:0] eng_p1,
  output logic [DATA_WIDTH-1:0] eng_p2,
  input  logic                  eng_done,
  input  logic [DATA_WIDTH-1:0] eng_x_out,
  input  logic [DATA_WIDTH-1:0] eng_y_out,
  output logic                  busy,
  output logic                  err_timeout,
`ifdef SEQ_PERF_CNT_EN
  output logic [15:0]           perf_points,
  output logic [7:0]            perf_timeouts,
`endif
  output logic [1:0]            state_dbg
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] TYPE_TRANSLATE = 2'b10;
  localparam logic [1:0] TYPE_BYPASS    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t state_q, state_d;

  logic [1:0]            prog_type [MAX_STEPS];
  logic [DATA_WIDTH-1:0] prog_p1   [MAX_STEPS];
  logic [DATA_WIDTH-1:0] prog_p2   [MAX_STEPS];

  logic [DATA_WIDTH-1:0] cur_x, cur_y;
  logic [AW-1:0]         step_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         len_clamp;
  logic [TW-1:0]         timer_q;

  logic accept, launch, step_done, timeout_hit, last_step;

  assign len_clamp = (cfg_len > LW'(MAX_STEPS)) ? LW'(MAX_STEPS) : cfg_len;
  assign last_step = ({1'b0, step_q} == (len_q - 1'b1));

  // Both handshakes (pt_*, res_*) transfer on a clock edge where valid && ready are
  // both high; valid-side data is held stable until that edge, ready may toggle freely.
  assign pt_ready  = (state_q == S_IDLE) && (cfg_len != '0);
  assign res_valid = (state_q == S_OUT);
  assign res_x     = cur_x;
  assign res_y     = cur_y;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    launch      = 1'b0;
    step_done   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pt_valid && pt_ready) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (prog_type[step_q] != TYPE_BYPASS) begin
          launch  = 1'b1;
          state_d = S_WAIT;
        end else begin
          step_done = 1'b1;
          state_d   = last_step ? S_OUT : S_ISSUE;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          step_done = 1'b1;
          state_d   = last_step ? S_OUT : S_ISSUE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_STEPS; i++) begin
        prog_type[i] <= TYPE_TRANSLATE;
        prog_p1[i]   <= '0;
        prog_p2[i]   <= '0;
      end
      cur_x       <= '0;
      cur_y       <= '0;
      step_q      <= '0;
      len_q       <= '0;
      timer_q     <= '0;
      eng_start   <= 1'b0;
      eng_x       <= '0;
      eng_y       <= '0;
      eng_type    <= '0;
      eng_p1      <= '0;
      eng_p2      <= '0;
      err_timeout <= 1'b0;
    end else begin
      // The program store only changes while no point is in flight.
      if (cfg_we && (state_q == S_IDLE)) begin
        prog_type[cfg_addr] <= cfg_type;
        prog_p1[cfg_addr]   <= cfg_p1;
        prog_p2[cfg_addr]   <= cfg_p2;
      end
      eng_start <= launch;
      if (accept) begin
        cur_x  <= pt_x;
        cur_y  <= pt_y;
        step_q <= '0;
        len_q  <= len_clamp;
      end
      if (launch) begin
        eng_x    <= cur_x;
        eng_y    <= cur_y;
        eng_type <= prog_type[step_q];
        eng_p1   <= prog_p1[step_q];
        eng_p2   <= prog_p2[step_q];
        timer_q  <= '0;
      end else if (state_q == S_WAIT) begin
        timer_q <= timer_q + 1'b1;
      end
      // A bypass step completes with cur untouched; an engine step takes the engine result.
      if (step_done) begin
        if (state_q == S_WAIT) begin
          cur_x <= eng_x_out;
          cur_y <= eng_y_out;
        end
        if (!last_step) step_q <= step_q + 1'b1;
      end
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_points   <= '0;
      perf_timeouts <= '0;
    end else begin
      if (res_valid && res_ready) perf_points <= perf_points + 16'd1;
      if (timeout_hit && (perf_timeouts != 8'hFF)) perf_timeouts <= perf_timeouts + 8'd1;
    end
  end
`endif

endmodule
